signed_divider_seq: RTL and testbench

SIGNED_DIVIDER_SEQ -- requirements
Module: signed_divider_seq

---
 rtl/signed_divider_seq.sv | 168 ++++++++++++++++
 tb/tb_signed_divider_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider_seq.sv
// Sequential truncating signed divider (restoring, one quotient bit per clk).
// Latency: result and ready appear N+2 edges after the edge that samples start.
// Backpressure: none; start restarts at any time and DONE holds its result.
// Optional build macro: DIVIDER_DBZ_DETECT_EN (divide-by-zero short cut and dbz flag).
module signed_divider_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         ready,
  output logic         busy,
  output logic         dbz
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t         state_q;
  // Dividend magnitude; quotient bits shift in from the LSB as dividend bits leave the MSB.
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  // Partial remainder is N+1 bits so the trial subtraction sign is always visible.
  logic [N:0]     rem_q;
  logic [CW-1:0]  cnt_q;
  logic           sign_a_q;
  logic           sign_q_q;
  logic [N-1:0]   quo_q;
  logic [N-1:0]   rmd_q;

  logic [N-1:0]   a_abs;
  logic [N-1:0]   b_abs;
  logic [N:0]     rem_sh;
  logic [N:0]     diff;
  logic [N:0]     rem_d;
  logic [N-1:0]   a_d;

  // Operand magnitudes; -2^(N-1) maps to 2^(N-1), which still fits as unsigned N bits.
  always_comb begin
    a_abs = A[N-1] ? -A : A;
    b_abs = B[N-1] ? -B : B;
  end

  // One restoring step: shift, trial-subtract, keep or restore.
  always_comb begin
    rem_sh = {rem_q[N-1:0], a_q[N-1]};
    diff   = rem_sh - {1'b0, b_q};
    if (diff[N]) begin
      rem_d = rem_sh;
      a_d   = {a_q[N-2:0], 1'b0};
    end else begin
      rem_d = diff;
      a_d   = {a_q[N-2:0], 1'b1};
    end
  end

`ifdef DIVIDER_DBZ_DETECT_EN
  logic dbz_q;

  // Control FSM and datapath registers, with the divide-by-zero short cut.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_q_q <= 1'b0;
      quo_q    <= '0;
      rmd_q    <= '0;
      dbz_q    <= 1'b0;
    end else if (start) begin
      a_q      <= a_abs;
      b_q      <= b_abs;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= A[N-1];
      sign_q_q <= A[N-1] ^ B[N-1];
      if (B == '0) begin
        quo_q   <= '1;
        rmd_q   <= A;
        dbz_q   <= 1'b1;
        state_q <= DONE;
      end else begin
        dbz_q   <= 1'b0;
        state_q <= ITER;
      end
    end else begin
      case (state_q)
        ITER: begin
          if (cnt_q == CW'(N)) begin
            state_q <= FIX;
          end else begin
            rem_q <= rem_d;
            a_q   <= a_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          quo_q   <= sign_q_q ? -a_q : a_q;
          rmd_q   <= sign_a_q ? -rem_q[N-1:0] : rem_q[N-1:0];
          state_q <= DONE;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign dbz = dbz_q;
`else
  // Control FSM and datapath registers; B=0 simply runs the normal iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_q_q <= 1'b0;
      quo_q    <= '0;
      rmd_q    <= '0;
    end else if (start) begin
      a_q      <= a_abs;
      b_q      <= b_abs;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= A[N-1];
      sign_q_q <= A[N-1] ^ B[N-1];
      state_q  <= ITER;
    end else begin
      case (state_q)
        ITER: begin
          // N working edges, then one edge that hands over to FIX.
          if (cnt_q == CW'(N)) begin
            state_q <= FIX;
          end else begin
            rem_q <= rem_d;
            a_q   <= a_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          quo_q   <= sign_q_q ? -a_q : a_q;
          rmd_q   <= sign_a_q ? -rem_q[N-1:0] : rem_q[N-1:0];
          state_q <= DONE;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign dbz = 1'b0;
`endif

  // Status flags are pure decodes of the state register.
  assign ready     = (state_q == DONE);
  assign busy      = (state_q == ITER) || (state_q == FIX);
  assign Quotient  = quo_q;
  assign Remainder = rmd_q;

endmodule

// File: tb/tb_signed_divider_seq.sv
// Directed table-driven bench for signed_divider_seq (N=8), plus abort, reload and reset sequences.
module tb_signed_divider_seq;

  localparam int N = 8;
`ifdef DIVIDER_DBZ_DETECT_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         ready;
  logic         busy;
  logic         dbz;

  int n_checks;
  int n_fail;

  signed_divider_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Quotient(Quotient), .Remainder(Remainder),
    .ready(ready), .busy(busy), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start for exactly one edge with the given operands.
  task automatic do_start(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until ready; -1 on timeout. busy_ok drops if busy is low before ready.
  task automatic wait_ready(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k;
        return;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit flag;
    logic [N-1:0] q_prev;
    int exp_lat;

    n_checks = 0;
    n_fail   = 0;

    //        A      B      Q      R
    vecs[0]  = '{8'd100, 8'd7,   8'h0E, 8'h02};
    vecs[1]  = '{8'h9C,  8'd7,   8'hF2, 8'hFE};   // -100 / 7
    vecs[2]  = '{8'd100, 8'hF9,  8'hF2, 8'h02};   // 100 / -7
    vecs[3]  = '{8'h9C,  8'hF9,  8'h0E, 8'hFE};   // -100 / -7
    vecs[4]  = '{8'h80,  8'hFF,  8'h80, 8'h00};   // -128 / -1 wraps
    vecs[5]  = '{8'h80,  8'd3,   8'hD6, 8'hFE};   // -128 / 3
    vecs[6]  = '{8'd0,   8'd5,   8'h00, 8'h00};
    vecs[7]  = '{8'd127, 8'd1,   8'h7F, 8'h00};
    vecs[8]  = '{8'hFF,  8'd2,   8'h00, 8'hFF};   // -1 / 2
    vecs[9]  = '{8'd7,   8'd100, 8'h00, 8'h07};
    vecs[10] = '{8'h15,  8'd0,   8'hFF, 8'h15};   // divide by zero
    vecs[11] = '{8'h80,  8'd0,   DBZ_EN ? 8'hFF : 8'h01, 8'h80};

    start = 1'b0;
    A     = '0;
    B     = '0;
    rst   = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_quotient",  Quotient,  0);
    check("reset_remainder", Remainder, 0);
    check("reset_ready",     ready,     0);
    check("reset_busy",      busy,      0);
    check("reset_dbz",       dbz,       0);
    // start is ignored while reset is held
    A = 8'd100; B = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    check("start_in_reset_busy", busy, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      exp_lat = (DBZ_EN && vecs[i].b == 0) ? 1 : N + 2;
      do_start(vecs[i].a, vecs[i].b);
      // the start edge itself is edge 0; continue counting from edge 1
      if (exp_lat == 1) begin
        lat = ready ? 1 : -1;
        busy_ok = 1'b1;
      end else begin
        check($sformatf("v%0d_busy_after_start", i), busy, 1);
        wait_ready(lat, busy_ok);
      end
      check($sformatf("v%0d_latency", i), lat, exp_lat);
      check($sformatf("v%0d_busy_ok", i), busy_ok, 1);
      check($sformatf("v%0d_quotient", i), Quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), Remainder, vecs[i].r);
      check($sformatf("v%0d_dbz", i), dbz, (DBZ_EN && vecs[i].b == 0) ? 1 : 0);
      check($sformatf("v%0d_busy_in_done", i), busy, 0);
    end

    // DONE holds its result while start stays low
    q_prev = Quotient;
    repeat (5) @(posedge clk);
    #1;
    check("done_hold_ready", ready, 1);
    check("done_hold_quotient", Quotient, q_prev);

    // Abort: 100/7 interrupted at the 4th ITER edge by 50/6
    q_prev = Quotient;
    do_start(8'd100, 8'd7);
    flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (ready || Quotient !== q_prev) flag = 1'b1;
    end
    do_start(8'd50, 8'd6);
    if (ready || Quotient !== q_prev) flag = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = k;
        break;
      end
      if (Quotient !== q_prev) flag = 1'b1;
    end
    check("abort_no_partial", flag, 0);
    check("abort_latency", lat, N + 2);
    check("abort_quotient", Quotient, 8'h08);
    check("abort_remainder", Remainder, 8'h02);

    // start held on three edges reloads each time; last operands win
    @(negedge clk);
    start = 1'b1; A = 8'd50; B = 8'd6;
    @(posedge clk); #1;
    A = 8'h9C; B = 8'd3;
    @(posedge clk); #1;
    A = 8'd100; B = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ready(lat, busy_ok);
    check("reload_latency", lat, N + 2);
    check("reload_quotient", Quotient, 8'h0E);
    check("reload_remainder", Remainder, 8'h02);

    // Asynchronous reset in the middle of ITER
    do_start(8'h9C, 8'd7);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_quotient",  Quotient,  0);
    check("arst_remainder", Remainder, 0);
    check("arst_ready",     ready,     0);
    check("arst_busy",      busy,      0);
    @(negedge clk);
    rst = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ready || busy) flag = 1'b1;
    end
    check("arst_no_result_after_release", flag, 0);
    do_start(8'd50, 8'd6);
    wait_ready(lat, busy_ok);
    check("post_reset_latency", lat, N + 2);
    check("post_reset_quotient", Quotient, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
